// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: shares a single-port, word-addressed instruction memory
// between the core fetch stage and a program loader. It holds the core in BOOT
// until the loader signals image completion, then arbitrates with a
// loader-burst starvation guard. Faulting fetches return NOP_INSTR.
// Optional build macro: IMEM_ARB_STATS_EN adds fetch/load/fault counters.
module imem_access_arbiter #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned MAX_LOAD_BURST = 4,
  parameter int unsigned BOOT_HOLD      = 1,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_fault,
  input  logic              load_req,
  input  logic [31:0]       load_addr,
  input  logic [31:0]       load_wdata,
  output logic              load_gnt,
  input  logic              load_done,
  output logic              core_hold,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_fetch_cnt,
  output logic [31:0]       stat_load_cnt,
  output logic [31:0]       stat_fault_cnt
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_LOAD_BURST);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  localparam state_t RST_STATE = (BOOT_HOLD != 0) ? BOOT : RUN;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_nxt;
  logic             fetch_bad;
  logic             load_bad;
  logic             rd_pend;
  logic [31:0]      instr_q;

  // Misaligned or beyond the memory depth.
  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
  endfunction

  assign fetch_bad = addr_fault(fetch_addr);
  assign load_bad  = addr_fault(load_addr);

  // State and burst counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RST_STATE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Next-state, arbitration and memory-port drive.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    core_hold = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (reset) begin
      core_hold = (BOOT_HOLD != 0);
    end else begin
      case (state)
        BOOT: begin
          load_gnt  = load_req;
          core_hold = 1'b1;
          burst_nxt = '0;
          if (load_done) state_nxt = RUN;
        end
        RUN: begin
          if (fetch_req && (burst_cnt == BURST_MAX)) begin
            fetch_gnt = 1'b1;
          end else if (load_req) begin
            load_gnt = 1'b1;
          end else if (fetch_req) begin
            fetch_gnt = 1'b1;
          end
          if (load_gnt) begin
            burst_nxt = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);
          end else begin
            burst_nxt = '0;
          end
          core_hold = fetch_req & ~fetch_gnt;
        end
        default: state_nxt = RST_STATE;
      endcase

      if (load_gnt && !load_bad) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = load_addr[ADDR_W+1:2];
        mem_wdata = load_wdata;
      end else if (fetch_gnt && !fetch_bad) begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr[ADDR_W+1:2];
      end
    end
  end

  // Fetch response pipeline; a faulting fetch loads NOP into the hold register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      rd_pend     <= 1'b0;
      instr_q     <= '0;
    end else begin
      fetch_valid <= fetch_gnt;
      fetch_fault <= fetch_gnt & fetch_bad;
      rd_pend     <= fetch_gnt & ~fetch_bad;
      if (rd_pend) instr_q <= mem_rdata;
      if (fetch_gnt && fetch_bad) instr_q <= NOP_INSTR;
    end
  end

  // Memory data is only live in the cycle after a read; otherwise hold.
  assign fetch_instr = rd_pend ? mem_rdata : instr_q;

`ifdef IMEM_ARB_STATS_EN
  // Free-running wrap-around activity counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetch_cnt <= '0;
      stat_load_cnt  <= '0;
      stat_fault_cnt <= '0;
    end else begin
      if (fetch_gnt)   stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
      if (load_gnt)    stat_load_cnt  <= stat_load_cnt + 32'd1;
      if (fetch_fault) stat_fault_cnt <= stat_fault_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Arbitrates the single-port, word-addressed instruction memory (256 x 32, 1 KB) between two requesters:
  - the core's fetch stage (PC-driven reads);
  - a program loader (writes that fill program memory at boot or at run time).
- Sequences boot: holds the core stalled until the loader declares the image complete.
- Converts byte addresses to word indices and flags faulting fetches.
- Sits between the PC/fetch logic and the memory array.

Parameters:
- ADDR_W, 8, word-index width; memory depth = 2**ADDR_W words.
- MAX_LOAD_BURST, 4, consecutive loader grants allowed in RUN before a pending fetch must win one slot; range 1..15.
- BOOT_HOLD, 1, 1 = come out of reset in BOOT; 0 = come out of reset in RUN.
- NOP_INSTR, 32'h00000013, instruction returned on a faulting fetch (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- fetch_req  input  1  core requests instruction at fetch_addr.
- fetch_addr  input  32  byte address (PC).
- fetch_gnt  output  1  fetch accepted this cycle (combinational).
- fetch_valid  output  1  fetch_instr valid; one cycle after grant.
- fetch_instr  output  32  fetched instruction.
- fetch_fault  output  1  with fetch_valid: misaligned or out-of-range address.
- load_req  input  1  loader write request.
- load_addr  input  32  byte address of write.
- load_wdata  input  32  instruction word to write.
- load_gnt  output  1  write accepted this cycle (combinational).
- load_done  input  1  single-cycle pulse: image complete.
- core_hold  output  1  stall the PC while high.
- mem_en  output  1  memory access enable.
- mem_we  output  1  write enable.
- mem_addr  output  ADDR_W  word index.
- mem_wdata  output  32  write data.
- mem_rdata  input  32  read data; synchronous, 1-cycle latency.

Behaviour:
- States:
  - BOOT: only the loader is served; fetch_gnt=0; core_hold=1.
  - RUN: both requesters arbitrated; core_hold = fetch_req & ~fetch_gnt.
- Transitions:
  - BOOT -> RUN on load_done=1. A load granted in the same cycle still completes.
  - load_done in RUN is ignored.
  - No other transitions.
- Reset (asserted any time, including mid-operation) forces:
  - state = BOOT if BOOT_HOLD else RUN;
  - burst_cnt=0; fetch_valid=0; fetch_fault=0; fetch_instr=0;
  - mem_en=0; mem_we=0; mem_addr=0; mem_wdata=0;
  - fetch_gnt=0; load_gnt=0; core_hold=BOOT_HOLD.
  - An in-flight read is discarded; no fetch_valid follows.
- Word index = addr[ADDR_W+1:2].
  - Misaligned: addr[1:0] != 0.
  - Out of range: any of addr[31:ADDR_W+2] nonzero.
- Arbitration in RUN, per cycle:
  - Loader wins unless fetch_req=1 and burst_cnt==MAX_LOAD_BURST; then fetch wins.
  - A load grant increments burst_cnt, saturating at MAX_LOAD_BURST.
  - A fetch grant, or a cycle with no load grant, clears burst_cnt to 0.
  - At most one grant per cycle.
- Granted load:
  - In range and aligned: mem_en=1, mem_we=1, mem_addr/mem_wdata driven.
  - Faulting address: load_gnt=1 but mem_en=0; the write is silently dropped.
- Granted fetch:
  - Valid address: mem_en=1, mem_we=0.
  - Cycle N+1: fetch_valid=1, fetch_instr=mem_rdata, fetch_fault=0.
  - Faulting address: no memory access; N+1: fetch_valid=1, fetch_instr=NOP_INSTR, fetch_fault=1.
- Every cycle without a grant in the previous cycle: fetch_valid=0. fetch_instr holds its last value.
- Read-after-write: a fetch of an address written in the prior cycle returns the new data, per array write-first timing.
- Back-to-back fetch grants give one fetch_valid per cycle (full throughput).

Optional Feature:
- IMEM_ARB_STATS_EN defined:
  - Adds outputs stat_fetch_cnt[31:0], stat_load_cnt[31:0], stat_fault_cnt[31:0].
  - Counters increment on fetch grant, load grant, and fetch_fault respectively; wrap at 2^32; cleared by reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Boot load: reset, BOOT_HOLD=1, loader writes 8 words (0x00940333 at 0x0 ... 0x00f768b3 at 0x1C), fetch_req=1 throughout -> fetch_gnt=0, core_hold=1 until load_done. The next cycle, fetch of 0x0 returns 0x00940333 with fetch_valid one cycle after grant.
- Streaming fetch: RUN, addresses 0x0,0x4,...,0x1C on consecutive cycles -> 8 consecutive fetch_valid cycles with words in order, fetch_fault=0.
- Starvation guard: MAX_LOAD_BURST=4, load_req and fetch_req held high -> grant pattern L,L,L,L,F repeating; load_gnt never exceeds 4 in a row.
- Faults: fetch 0x2 -> NOP_INSTR 0x00000013, fault=1, mem_en=0. Fetch 0x400 (ADDR_W=8) -> same. Load to 0x400 -> load_gnt=1, mem_en=0, memory unchanged.
- Reset mid-read: assert reset in the cycle after a fetch grant -> fetch_valid stays 0, state returns to BOOT, core_hold=1 immediately (asynchronous).
- Stats (IMEM_ARB_STATS_EN): 5 fetches, 3 loads, 1 misaligned fetch -> fetch_cnt=6, load_cnt=3, fault_cnt=1.
